// File: rtl/srl_iter_if.sv
// rtl/srl_iter_if.sv - start/busy/done request and result bundle for the iterative right shifter
interface srl_iter_if #(
    parameter int n       = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [n-1:0]       num;
    logic [SHAMT_W-1:0] shamt;
    logic               arith;
    logic               busy;
    logic               done;
    logic [n-1:0]       result;

    modport master (
        output start, num, shamt, arith,
        input  busy, done, result
    );

    modport slave (
        input  start, num, shamt, arith,
        output busy, done, result
    );
endinterface

// File: rtl/srl_iter.sv
// rtl/srl_iter.sv - multi-cycle logical/arithmetic right shifter; SRL_ITER_FAST4_EN enables 4-bit steps
module srl_iter #(
    parameter int n       = 32,
    parameter int SHAMT_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    srl_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [n-1:0]       sreg, sreg_next;
    logic [n-1:0]       result, result_next;
    logic [SHAMT_W-1:0] cnt, cnt_next;
    logic               fill, fill_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sreg   <= '0;
            result <= '0;
            cnt    <= '0;
            fill   <= 1'b0;
        end else begin
            state  <= state_next;
            sreg   <= sreg_next;
            result <= result_next;
            cnt    <= cnt_next;
            fill   <= fill_next;
        end
    end

    always_comb begin
        state_next  = state;
        sreg_next   = sreg;
        result_next = result;
        cnt_next    = cnt;
        fill_next   = fill;
        case (state)
            IDLE, DONE: begin
                // DONE accepts a new request so back-to-back operations lose no cycle
                if (bus.start) begin
                    sreg_next  = bus.num;
                    cnt_next   = bus.shamt;
                    fill_next  = bus.arith & bus.num[n-1];
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    result_next = sreg;
                    state_next  = DONE;
                end else begin
`ifdef SRL_ITER_FAST4_EN
                    if (cnt >= SHAMT_W'(4)) begin
                        sreg_next = {{4{fill}}, sreg[n-1:4]};
                        cnt_next  = cnt - SHAMT_W'(4);
                    end else begin
                        sreg_next = {fill, sreg[n-1:1]};
                        cnt_next  = cnt - SHAMT_W'(1);
                    end
`else
                    sreg_next = {fill, sreg[n-1:1]};
                    cnt_next  = cnt - SHAMT_W'(1);
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy   = (state == SHIFT);
    assign bus.done   = (state == DONE);
    assign bus.result = result;
endmodule

// File: tb/tb_srl_iter.sv
// tb/tb_srl_iter.sv - directed vector bench for srl_iter
module tb_srl_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    srl_iter_if #(.n(32), .SHAMT_W(5)) bus ();

    srl_iter #(.n(32), .SHAMT_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] num;
        logic [4:0]  shamt;
        logic        arith;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic int exp_lat(input int s);
`ifdef SRL_ITER_FAST4_EN
        return 1 + s / 4 + s % 4;
`else
        return s + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Entered at the negedge right after the accept edge; returns edges from accept to done.
    task automatic wait_done(input logic [31:0] held, output int lat, output bit ok);
        lat = 0;
        ok  = (bus.busy === 1'b1) && (bus.done === 1'b0) && (bus.result === held);
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done !== 1'b1 && (bus.busy !== 1'b1 || bus.result !== held)) ok = 0;
            if (bus.done === 1'b1 && bus.busy !== 1'b0) ok = 0;
        end
    endtask

    task automatic accept(input logic [31:0] num, input logic [4:0] shamt, input logic arith);
        bus.start = 1'b1;
        bus.num   = num;
        bus.shamt = shamt;
        bus.arith = arith;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.num   = $urandom;
        bus.shamt = 5'($urandom);
        bus.arith = 1'($urandom);
    endtask

    logic [31:0] prev = 32'h0;
    int          lat;
    bit          ok;
    bit          saw_done;

    initial begin
        vecs[0] = '{32'h0000BEEF, 5'd5,  1'b0, 32'h000005F7};
        vecs[1] = '{32'hF0000000, 5'd4,  1'b1, 32'hFF000000};
        vecs[2] = '{32'hF0000000, 5'd4,  1'b0, 32'h0F000000};
        vecs[3] = '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001};
        vecs[4] = '{32'h13579BDF, 5'd0,  1'b0, 32'h13579BDF};
        vecs[5] = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
        vecs[6] = '{32'h80000000, 5'd31, 1'b0, 32'h00000001};
        vecs[7] = '{32'h12345678, 5'd8,  1'b1, 32'h00123456};
        vecs[8] = '{32'h87654321, 5'd7,  1'b1, 32'hFF0ECA86};
        vecs[9] = '{32'h7FFFFFFF, 5'd30, 1'b1, 32'h00000001};

        bus.start = 1'b0;
        bus.num   = '0;
        bus.shamt = '0;
        bus.arith = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        check("reset_done", {31'b0, bus.done}, 32'h0);
        check("reset_result", bus.result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].num, vecs[i].shamt, vecs[i].arith);
            wait_done(prev, lat, ok);
            check($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, exp_lat(int'(vecs[i].shamt)));
            check($sformatf("vec%0d_busy_hold", i), {31'b0, ok}, 32'h1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'b0, bus.done}, 32'h0);
            check($sformatf("vec%0d_result_held", i), bus.result, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // start pulsed while busy must not disturb the operation in flight
        bus.start = 1'b1; bus.num = 32'hA5A5A5A5; bus.shamt = 5'd3; bus.arith = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.num = 32'h00FF00FF; bus.shamt = 5'd1; bus.arith = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(prev, lat, ok);
        check("ignored_start_result", bus.result, 32'hF4B4B4B4);
        check("ignored_start_latency", lat + 1, exp_lat(3));
        saw_done = 1'b0;
        @(posedge clk);
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        check("ignored_start_no_second_op", {31'b0, saw_done}, 32'h0);
        prev = 32'hF4B4B4B4;

        // back-to-back: second start issued in the DONE cycle
        accept(32'h0000BEEF, 5'd5, 1'b0);
        wait_done(prev, lat, ok);
        check("b2b_first_result", bus.result, 32'h000005F7);
        accept(32'h00000111, 5'd4, 1'b0);
        wait_done(32'h000005F7, lat, ok);
        check("b2b_second_result", bus.result, 32'h00000011);
        check("b2b_second_latency", lat, exp_lat(4));
        check("b2b_first_held", {31'b0, ok}, 32'h1);
        @(posedge clk);
        @(negedge clk);

        // reset mid-shift discards the operation without a done pulse
        bus.start = 1'b1; bus.num = 32'hCAFEF00D; bus.shamt = 5'd20; bus.arith = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); bus.start = 1'b1; bus.num = 32'h11111111; bus.shamt = 5'd1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        check("midreset_busy_before", {31'b0, bus.busy}, 32'h1);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_busy", {31'b0, bus.busy}, 32'h0);
        check("midreset_done", {31'b0, bus.done}, 32'h0);
        check("midreset_result", bus.result, 32'h0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("midreset_no_done", {31'b0, saw_done}, 32'h0);

        accept(32'hF0000000, 5'd4, 1'b1);
        wait_done(32'h0, lat, ok);
        check("post_reset_result", bus.result, 32'hFF000000);
        check("post_reset_busy_hold", {31'b0, ok}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
